// File: rtl/ac3_quant_bank.sv
// Multi-channel AC3 result bank: holds NCH accumulators, then shifts, rounds and saturates all of them.
// Define AC3Q_ROUND_EN for round-half-up; by default the result is truncated (floor).
module ac3_quant_bank #(
   parameter int unsigned M    = 16,
   parameter int unsigned Pa   = 8,
   parameter int unsigned Pw   = 4,
   parameter int unsigned MNO  = 288,
   parameter int unsigned NCH  = 4,
   parameter int unsigned POUT = 8,
   localparam int unsigned W   = $clog2(M) + Pa + Pw + $clog2(MNO),
   localparam int unsigned SHW = $clog2(W)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cl_en,
   input  logic [NCH-1:0]        w_en,
   input  logic [NCH*W-1:0]      inr,
   input  logic                  q_start,
   input  logic [SHW-1:0]        shamt,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  out_valid,
   output logic [NCH*POUT-1:0]   outq,
   output logic [NCH-1:0]        sat_flag,
   output logic [NCH*W-1:0]      outr
);

   typedef enum logic [1:0] {StIdle, StShift, StSat, StValid} state_e;

   localparam logic signed [W:0] QMAX = {{(W-POUT+2){1'b0}}, {(POUT-1){1'b1}}};
   localparam logic signed [W:0] QMIN = ~QMAX;

   state_e                r_state, w_state_d;
   logic [SHW-1:0]        r_cnt, w_cnt_d;
   logic [NCH*W-1:0]      r_outr, w_outr_d;
   logic [NCH*POUT-1:0]   r_outq, w_outq_d;
   logic [NCH-1:0]        r_sat, w_sat_d;
   logic                  r_valid, w_valid_d;
   logic [NCH-1:0]        w_rnd;
   logic [SHW-1:0]        w_cnt_start;
   logic                  w_accept;
   logic signed [W:0]     w_v [NCH];

   assign w_cnt_start = (shamt > SHW'(W-1)) ? SHW'(W-1) : shamt;
   // A write in the same cycle wins over q_start.
   assign w_accept    = (r_state == StIdle) && q_start && !(|w_en);

`ifdef AC3Q_ROUND_EN
   logic [NCH-1:0] r_rnd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rnd <= '0;
      end else if (cl_en || w_accept) begin
         r_rnd <= '0;
      end else if (r_state == StShift) begin
         for (int unsigned c = 0; c < NCH; c++) begin
            r_rnd[c] <= r_outr[c*W];
         end
      end
   end

   assign w_rnd = r_rnd;
`else
   assign w_rnd = '0;
`endif

   always_comb begin
      for (int unsigned c = 0; c < NCH; c++) begin
         w_v[c] = $signed({r_outr[c*W+W-1], r_outr[c*W +: W]}) + $signed({{W{1'b0}}, w_rnd[c]});
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_outr_d  = r_outr;
      w_outq_d  = r_outq;
      w_sat_d   = r_sat;
      w_valid_d = r_valid;
      if (cl_en) begin
         w_state_d = StIdle;
         w_cnt_d   = '0;
         w_outr_d  = '0;
         w_outq_d  = '0;
         w_sat_d   = '0;
         w_valid_d = 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (|w_en) begin
                  for (int unsigned c = 0; c < NCH; c++) begin
                     if (w_en[c]) begin
                        w_outr_d[c*W +: W] = inr[c*W +: W];
                     end
                  end
               end else if (q_start) begin
                  w_cnt_d   = w_cnt_start;
                  w_state_d = (w_cnt_start != '0) ? StShift : StSat;
               end
            end
            StShift: begin
               for (int unsigned c = 0; c < NCH; c++) begin
                  w_outr_d[c*W +: W] = {r_outr[c*W+W-1], r_outr[c*W+1 +: W-1]};
               end
               w_cnt_d = r_cnt - SHW'(1);
               if (r_cnt == SHW'(1)) begin
                  w_state_d = StSat;
               end
            end
            StSat: begin
               for (int unsigned c = 0; c < NCH; c++) begin
                  if (w_v[c] > QMAX) begin
                     w_outq_d[c*POUT +: POUT] = {1'b0, {(POUT-1){1'b1}}};
                     w_sat_d[c]               = 1'b1;
                  end else if (w_v[c] < QMIN) begin
                     w_outq_d[c*POUT +: POUT] = {1'b1, {(POUT-1){1'b0}}};
                     w_sat_d[c]               = 1'b1;
                  end else begin
                     w_outq_d[c*POUT +: POUT] = w_v[c][POUT-1:0];
                     w_sat_d[c]               = 1'b0;
                  end
               end
               w_valid_d = 1'b1;
               w_state_d = StValid;
            end
            StValid: begin
               if (out_ready) begin
                  w_valid_d = 1'b0;
                  w_state_d = StIdle;
               end
            end
            default: w_state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_outr  <= '0;
         r_outq  <= '0;
         r_sat   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_outr  <= w_outr_d;
         r_outq  <= w_outq_d;
         r_sat   <= w_sat_d;
         r_valid <= w_valid_d;
      end
   end

   assign busy      = (r_state != StIdle);
   assign out_valid = r_valid;
   assign outq      = r_outq;
   assign sat_flag  = r_sat;
   assign outr      = r_outr;

endmodule

// File: tb/tb_ac3_quant_bank.sv
// Randomized and directed bench for ac3_quant_bank against an integer reference model.
module tb_ac3_quant_bank;

   localparam int unsigned NCH  = 4;
   localparam int unsigned POUT = 8;
   localparam int unsigned W    = 25;
   localparam int unsigned SHW  = 5;
`ifdef AC3Q_ROUND_EN
   localparam bit RoundEn = 1'b1;
`else
   localparam bit RoundEn = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst_n;
   logic                cl_en;
   logic [NCH-1:0]      w_en;
   logic [NCH*W-1:0]    inr;
   logic                q_start;
   logic [SHW-1:0]      shamt;
   logic                out_ready;
   logic                busy;
   logic                out_valid;
   logic [NCH*POUT-1:0] outq;
   logic [NCH-1:0]      sat_flag;
   logic [NCH*W-1:0]    outr;

   int     n_vec = 0;
   int     n_err = 0;
   longint regs [NCH];

   ac3_quant_bank dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cl_en     (cl_en),
      .w_en      (w_en),
      .inr       (inr),
      .q_start   (q_start),
      .shamt     (shamt),
      .out_ready (out_ready),
      .busy      (busy),
      .out_valid (out_valid),
      .outq      (outq),
      .sat_flag  (sat_flag),
      .outr      (outr)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic longint q_of(input int c);
      return longint'($signed(outq[c*POUT +: POUT]));
   endfunction

   function automatic longint r_of(input int c);
      return longint'($signed(outr[c*W +: W]));
   endfunction

   function automatic int eff_shift(input int sh);
      return (sh > W - 1) ? W - 1 : sh;
   endfunction

   // Quantized value of x: floor(x / 2^s), plus the half bit when rounding, then clamp.
   function automatic longint ref_q(input longint x, input int s, output bit sat);
      longint v;
      v = x >>> s;
      if (RoundEn && s > 0) v = v + ((x >>> (s - 1)) & 1);
      sat = 1'b0;
      if (v > 127) begin
         v = 127;
         sat = 1'b1;
      end else if (v < -128) begin
         v = -128;
         sat = 1'b1;
      end
      return v;
   endfunction

   task automatic write_ch(input logic [NCH-1:0] mask, input longint v0, input longint v1,
                           input longint v2, input longint v3);
      longint vals [NCH];
      vals = '{v0, v1, v2, v3};
      w_en = mask;
      for (int c = 0; c < NCH; c++) begin
         inr[c*W +: W] = vals[c][W-1:0];
         if (mask[c]) regs[c] = vals[c];
      end
      tick();
      w_en = '0;
   endtask

   // Starts a quantization, checks latency and the presented result, leaves the DUT in VALID.
   task automatic start_and_wait(input int sh, input bit poke);
      int lat;
      int s;
      bit sat;
      longint exp_q;
      s = eff_shift(sh);
      shamt = SHW'(sh);
      q_start = 1'b1;
      tick();
      q_start = 1'b0;
      check_eq("busy_rise", longint'(busy), 1);
      lat = 0;
      if (poke) begin
         w_en = 4'b0001;
         inr[W-1:0] = 25'd7;
         tick();
         lat++;
         w_en = '0;
      end
      while (!out_valid && lat < 64) begin
         tick();
         lat++;
      end
      check_eq("latency", lat, s + 1);
      for (int c = 0; c < NCH; c++) begin
         exp_q = ref_q(regs[c], s, sat);
         check_eq($sformatf("outq%0d", c), q_of(c), exp_q);
         check_eq($sformatf("sat%0d", c), longint'(sat_flag[c]), longint'(sat));
         regs[c] = regs[c] >>> s;
         check_eq($sformatf("outr%0d", c), r_of(c), regs[c]);
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq("valid_fall", longint'(out_valid), 0);
      check_eq("busy_fall", longint'(busy), 0);
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, "_busy"}, longint'(busy), 0);
      check_eq({tag, "_valid"}, longint'(out_valid), 0);
      check_eq({tag, "_outq"}, longint'(outq), 0);
      check_eq({tag, "_sat"}, longint'(sat_flag), 0);
      check_eq({tag, "_outr_or"}, longint'(|outr), 0);
   endtask

   initial begin
      rst_n = 1'b0; cl_en = 1'b0; w_en = '0; inr = '0;
      q_start = 1'b0; shamt = '0; out_ready = 1'b0;
      for (int c = 0; c < NCH; c++) regs[c] = 0;
      #12;
      check_zero("reset");
      rst_n = 1'b1;
      tick();

      // Rounding vs. truncation on +/-1000 >> 4.
      write_ch(4'b1111, 1000, -1000, 3, -3);
      start_and_wait(4, 1'b0);
      check_eq("r1000", q_of(0), RoundEn ? 63 : 62);
      check_eq("rm1000", q_of(1), RoundEn ? -62 : -63);
      handshake();

      // Saturation both ways.
      write_ch(4'b1111, 3, -3, 100000, -100000);
      start_and_wait(2, 1'b0);
      check_eq("sat_pos", q_of(2), 127);
      check_eq("sat_neg", q_of(3), -128);
      check_eq("sat_mask", longint'(sat_flag), 4'b1100);
      handshake();

      // q_start with a write is ignored.
      w_en = 4'b0001; inr[W-1:0] = 25'd5; regs[0] = 5; q_start = 1'b1; shamt = 5'd3;
      tick();
      w_en = '0; q_start = 1'b0;
      check_eq("qs_with_write", longint'(busy), 0);

      // shamt = 0, output held under back-pressure, new requests ignored.
      start_and_wait(0, 1'b0);
      check_eq("sh0_q", q_of(0), 5);
      q_start = 1'b1; shamt = 5'd3; w_en = 4'b0001; inr[W-1:0] = 25'd99;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("hold_valid", longint'(out_valid), 1);
         check_eq("hold_q", q_of(0), 5);
         check_eq("hold_r", r_of(0), 5);
      end
      q_start = 1'b0; w_en = '0;
      handshake();

      // Write during SHIFT ignored; shamt clamps to W-1.
      write_ch(4'b1111, 1000, -1000, 1 << 22, -77);
      start_and_wait(31, 1'b1);
      if (!RoundEn) begin
         check_eq("clamp_pos", q_of(0), 0);
         check_eq("clamp_neg", q_of(1), -1);
      end
      handshake();

      // cl_en in VALID.
      write_ch(4'b1111, 12345, -54321, 77, -8);
      start_and_wait(3, 1'b0);
      cl_en = 1'b1;
      tick();
      cl_en = 1'b0;
      for (int c = 0; c < NCH; c++) regs[c] = 0;
      check_zero("clear");

      // Asynchronous reset in mid-SHIFT.
      write_ch(4'b1111, 4000, -4000, 9, 100);
      shamt = 5'd10; q_start = 1'b1;
      tick();
      q_start = 1'b0;
      tick(); tick(); tick();
      #2 rst_n = 1'b0;
      #1 check_zero("rst_mid");
      for (int c = 0; c < NCH; c++) regs[c] = 0;
      #1 rst_n = 1'b1;
      tick();

      // Randomized transactions.
      for (int it = 0; it < 40; it++) begin
         longint v [NCH];
         int sh;
         for (int c = 0; c < NCH; c++) begin
            v[c] = longint'($signed($urandom)) >>> $urandom_range(7, 28);
         end
         write_ch(4'($urandom), v[0], v[1], v[2], v[3]);
         sh = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 31) : $urandom_range(0, 12);
         start_and_wait(sh, 1'($urandom_range(0, 1)) && (sh > 1));
         repeat ($urandom_range(0, 3)) begin
            tick();
            check_eq("rnd_hold", longint'(out_valid), 1);
         end
         handshake();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
